// File: rtl/muldiv_seq.sv
// Iterative signed multiply/divide/remainder: one shift-add or restoring-subtract step per cycle.
// Holds busy while working so the execute stage stalls; result is presented with a one-cycle done.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    // state  | meaning
    // IDLE   | waiting for start; busy low
    // RUN    | one iteration per cycle, counter counting down
    // DONE   | result presented, done pulse unless flushed
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_MUL = 2'd0;
    localparam logic [1:0] OP_DIV = 2'd1;
    localparam logic [1:0] OP_REM = 2'd2;

    logic [1:0]       state;
    logic [1:0]       op_r;
    logic             neg_r;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] res_r;
    logic [WIDTH-1:0] y_r;
    logic             dz_r;
    logic             dz_hold;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] acc_nx;
    logic [WIDTH-1:0] sh_nx;
    logic [WIDTH-1:0] opnd_nx;
    logic [WIDTH-1:0] result;

    logic accept;
    logic div_op;
    logic dz_start;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    assign accept   = (state == S_IDLE) && start && !flush;
    assign div_op   = (op == OP_DIV) || (op == OP_REM);
    assign dz_start = div_op && (b == '0);

    // MUL keeps acc as the running low product; DIV/REM use acc as the partial
    // remainder and sh as dividend bits shifting out / quotient bits shifting in.
    always_comb begin
        shifted = {acc, sh[WIDTH-1]};
        diff    = shifted - {1'b0, opnd};
        acc_nx  = acc;
        sh_nx   = sh;
        opnd_nx = opnd;
        if (op_r == OP_MUL) begin
            acc_nx  = sh[0] ? acc + opnd : acc;
            sh_nx   = sh >> 1;
            opnd_nx = opnd << 1;
        end else if (!diff[WIDTH]) begin
            acc_nx = diff[WIDTH-1:0];
            sh_nx  = {sh[WIDTH-2:0], 1'b1};
        end else begin
            acc_nx = shifted[WIDTH-1:0];
            sh_nx  = {sh[WIDTH-2:0], 1'b0};
        end
        case (op_r)
            OP_MUL:  result = acc_nx;
            OP_DIV:  result = neg_r ? -sh_nx : sh_nx;
            default: result = neg_r ? -acc_nx : acc_nx;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            op_r    <= OP_MUL;
            neg_r   <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            sh      <= '0;
            opnd    <= '0;
            res_r   <= '0;
            y_r     <= '0;
            dz_r    <= 1'b0;
            dz_hold <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_r    <= (op == 2'b11) ? OP_MUL : op;
                        cnt     <= CW'(WIDTH);
                        acc     <= '0;
                        dz_hold <= 1'b0;
                        if (div_op) begin
                            sh    <= mag(a);
                            opnd  <= mag(b);
                            neg_r <= (op == OP_DIV) ? (a[WIDTH-1] ^ b[WIDTH-1]) : a[WIDTH-1];
                        end else begin
                            sh    <= b;
                            opnd  <= a;
                            neg_r <= 1'b0;
                        end
                        if (dz_start) begin
                            state <= S_DONE;
                            res_r <= '1;
                            dz_r  <= 1'b1;
                        end else begin
                            state <= S_RUN;
                            dz_r  <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        acc  <= acc_nx;
                        sh   <= sh_nx;
                        opnd <= opnd_nx;
                        cnt  <= cnt - CW'(1);
                        if (cnt == CW'(1)) begin
                            state <= S_DONE;
                            res_r <= result;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    if (!flush) begin
                        y_r     <= res_r;
                        dz_hold <= dz_r;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // The fresh result is visible during the done cycle and only commits to
    // the holding registers if that cycle was not flushed.
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE) && !flush;
    assign y           = done ? res_r : y_r;
    assign div_by_zero = done ? dz_r : dz_hold;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed corners plus random operations against a
// plain-arithmetic reference (64-bit signed divide/remainder, truncated product).
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] y;
    logic        div_by_zero;

    int errors = 0;
    int checks = 0;
    logic [31:0] last_y = '0;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .y(y), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                                  output logic [31:0] ey, output logic edz, output int lat);
        longint sa, sb, q, r;
        sa = longint'($signed(aa));
        sb = longint'($signed(bb));
        edz = 1'b0;
        lat = 33;
        if (o == 2'd1 || o == 2'd2) begin
            if (bb == 0) begin
                ey = 32'hFFFF_FFFF;
                edz = 1'b1;
                lat = 1;
            end else begin
                q = sa / sb;
                r = sa % sb;
                ey = (o == 2'd1) ? q[31:0] : r[31:0];
            end
        end else begin
            ey = aa * bb;
        end
    endfunction

    task automatic do_op(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                         input bit hold, input string tag);
        logic [31:0] ey;
        logic edz;
        int lat, n, got, busy_low, dones;
        model(o, aa, bb, ey, edz, lat);
        @(negedge clk);
        op = o; a = aa; b = bb; start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        a = $urandom; b = $urandom;
        got = -1; busy_low = 0; dones = 0;
        for (n = 1; n <= 40 && got < 0; n++) begin
            @(negedge clk);
            if (!busy) busy_low++;
            if (done) begin
                got = n;
                dones++;
                chk({tag, "_y"}, y, ey);
                chk({tag, "_dbz"}, 32'(div_by_zero), 32'(edz));
            end
        end
        chk({tag, "_latency"}, 32'(got), 32'(lat));
        chk({tag, "_busy"}, 32'(busy_low), 32'd0);
        start = 1'b0;
        @(negedge clk);
        if (done) dones++;
        chk({tag, "_onedone"}, 32'(dones), 32'd1);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_hold"}, y, ey);
        last_y = ey;
    endtask

    initial begin
        int dcount;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_y", y, 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        rst = 1'b0;

        do_op(2'd0, 32'd7, 32'hFFFF_FFFD, 1'b0, "mul_7_m3");
        chk("mul_7_m3_const", last_y, 32'hFFFF_FFEB);
        do_op(2'd1, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_m7_2");
        do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, "rem_m7_2");
        do_op(2'd1, 32'd5, 32'd0, 1'b0, "div_by0");
        do_op(2'd0, 32'd3, 32'd4, 1'b0, "mul_3_4");
        do_op(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "rem_ovf");
        do_op(2'd3, 32'd9, 32'hFFFF_FFFF, 1'b0, "op11_mul");
        do_op(2'd2, 32'd17, 32'd0, 1'b0, "rem_by0");
        do_op(2'd0, 32'd6, 32'd6, 1'b1, "held_start");

        for (int i = 0; i < 16; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 5) == 0) rb = '0;
            else if ($urandom_range(0, 2) == 0) rb = 32'($urandom_range(1, 100));
            if ($urandom_range(0, 3) == 0) rb = -rb;
            do_op(ro, ra, rb, 1'b0, "rand");
        end

        // flush mid-RUN: accepted in cycle 0, flushed in cycle 10
        @(negedge clk);
        op = 2'd0; a = 32'd11; b = 32'd13; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dcount = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) dcount++;
        end
        flush = 1'b1;
        @(negedge clk);
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_done", 32'(done), 32'd0);
        chk("flush_y", y, last_y);
        flush = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("flush_nodone", 32'(dcount), 32'd0);
        chk("flush_y_after", y, last_y);

        // start together with flush in IDLE is not accepted
        @(negedge clk);
        start = 1'b1; flush = 1'b1;
        @(negedge clk);
        chk("startflush_busy", 32'(busy), 32'd0);
        start = 1'b0; flush = 1'b0;

        // asynchronous reset mid-RUN
        @(negedge clk);
        op = 2'd1; a = 32'd1000; b = 32'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_y", y, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_y = '0;
        do_op(2'd2, 32'd1000, 32'd7, 1'b0, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Iterative multiply/divide unit sequenced alongside the execute stage. It takes MUL/DIV/REM operations whose opcodes the ALU does not cover. It runs one shift-add or restoring-subtract step per cycle under a small FSM, and holds busy so the pipeline control logic stalls the execute stage. It returns the result with a one-cycle done pulse.

Parameters:
WIDTH, 32, operand/result width in bits; the iteration counter is clog2(WIDTH)+1 bits wide.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
op  input  2  00 MUL, 01 DIV, 10 REM, 11 treated as MUL
a  input  WIDTH  operand A (multiplicand / dividend), signed two's complement
b  input  WIDTH  operand B (multiplier / divisor), signed two's complement
flush  input  1  abort the current operation (pipeline annul/exception)
busy  output  1  high in RUN and DONE; execute stage stalls while high
done  output  1  single-cycle pulse; y and div_by_zero are valid in that cycle
y  output  WIDTH  result register
div_by_zero  output  1  set with done when op is DIV/REM and b == 0

Behaviour:
- Reset (async, any state): FSM to IDLE; busy=0, done=0, y=0, div_by_zero=0, counter=0, internal accumulators=0.
- States: IDLE, RUN, DONE.
- IDLE: busy=0.
  - start=1 and flush=0: latch op and operand magnitudes; record result sign.
    - MUL: no sign fixup needed, because the low WIDTH bits of the product are sign-agnostic.
    - DIV: quotient negative iff a[MSB]^b[MSB].
    - REM: remainder takes the sign of a.
  - Counter loads WIDTH. Go to RUN.
  - Exception: DIV/REM with b==0 goes directly to DONE with y=all-ones, div_by_zero=1.
- RUN: one iteration per cycle; the counter decrements, and the FSM goes to DONE when the count reaches 0.
  - MUL: shift-add on the multiplier LSB; keep the low WIDTH bits only.
  - DIV/REM: restoring divide, 1 quotient bit per cycle.
- DONE: y loads the sign-corrected result; done=1 for exactly this one cycle; busy=1. The next state is IDLE.
- Latency, with start accepted in cycle 0:
  - Normal operation: RUN occupies cycles 1..WIDTH; done is high in cycle WIDTH+1 (cycle 33 for WIDTH=32).
  - Divide-by-zero: done is high in cycle 1.
- After done: y and div_by_zero hold their values until the next done. div_by_zero clears on the next accepted start.
- start while busy=1: ignored, with no queueing. The requester must hold start until it observes busy deasserted.
- Signed edge case: DIV of the most-negative value by -1 yields the most-negative value (wraps); REM of the same yields 0. No flag is raised.
- Operands: a and b are sampled only at acceptance; changes during RUN have no effect.
- flush:
  - In RUN or DONE: next state is IDLE; done is suppressed (it is 0 that cycle if the FSM was in DONE); y is unchanged; busy=0 next cycle.
  - In IDLE: any simultaneous start is ignored.
- Reset mid-operation: immediate return to the reset state; no done pulse.
- Back-to-back operation: a start presented in the cycle after DONE (FSM in IDLE) is accepted. The minimum spacing between accepted starts is WIDTH+2 cycles.

Test Plan:
- Reset then MUL: a=7, b=0xFFFFFFFD (-3), start in cycle 0 -> busy in cycles 1..33; done only in cycle 33; y=0xFFFFFFEB (-21); div_by_zero=0.
- DIV/REM signed: a=0xFFFFFFF9 (-7), b=2 -> DIV gives y=0xFFFFFFFD (-3); REM gives y=0xFFFFFFFF (-1); done at cycle 33 for each.
- Divide by zero: DIV a=5, b=0 -> done and div_by_zero in cycle 1; y=0xFFFFFFFF. The next MUL 3*4 clears div_by_zero and gives y=12.
- Overflow corner: DIV a=0x80000000, b=0xFFFFFFFF -> y=0x80000000. REM with the same operands -> y=0.
- Flush: start MUL in cycle 0, flush in cycle 10 -> busy=0 from cycle 11; no done; y keeps its previous value. start with flush both high in IDLE -> no acceptance.
- Busy/reset: start held high during RUN produces only one done. rst asserted mid-RUN asynchronously clears busy, done and y to 0.
